// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the frequency meter.
package freq_meter_pkg;

    typedef enum logic {
        StIdle    = 1'b0,
        StMeasure = 1'b1
    } state_e;

    localparam int unsigned DefGateCycles = 50_000_000;
    localparam int unsigned DefCntW       = 27;

    function automatic int unsigned gate_cnt_w(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Three-flop synchronizer for an asynchronous input with a rising-edge strobe.
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o
);

    // sync_q[0] is the metastability catcher; rise is taken between stages 2 and 3.
    logic [2:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
        end
    end

    assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous input over a fixed gate window.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DefGateCycles,
    parameter int unsigned CNT_W       = DefCntW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             start,
    input  logic             continuous,
    output logic [CNT_W-1:0] freq_out,
    output logic             valid,
    output logic             busy,
    output logic             overflow
);

    localparam int unsigned       GateW    = gate_cnt_w(GATE_CYCLES);
    localparam logic [GateW-1:0]  GateLast = GateW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  EdgeMax  = '1;

    state_e           state_q, state_d;
    logic [GateW-1:0] gate_q, gate_d;
    logic [CNT_W-1:0] edge_q, edge_d, edge_nxt;
    logic             ovf_q, ovf_d, ovf_nxt;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic             overflow_q, overflow_d;
    logic             valid_q, valid_d;
    logic             rise;

    sync_edge_det u_sync (
        .clk_i   (clock),
        .rst_i   (reset),
        .async_i (sig_in),
        .rise_o  (rise)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            gate_q     <= '0;
            edge_q     <= '0;
            ovf_q      <= 1'b0;
            freq_q     <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            edge_q     <= edge_d;
            ovf_q      <= ovf_d;
            freq_q     <= freq_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    // Saturating edge count including this cycle's rise; used both mid-window and at the end.
    always_comb begin
        edge_nxt = edge_q;
        ovf_nxt  = ovf_q;
        if (rise) begin
            if (edge_q == EdgeMax) begin
                ovf_nxt = 1'b1;
            end else begin
                edge_nxt = edge_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        edge_d     = edge_q;
        ovf_d      = ovf_q;
        freq_d     = freq_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start || continuous) begin
                    state_d = StMeasure;
                    gate_d  = '0;
                    edge_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            StMeasure: begin
                if (gate_q == GateLast) begin
                    freq_d     = edge_nxt;
                    overflow_d = ovf_nxt;
                    valid_d    = 1'b1;
                    gate_d     = '0;
                    edge_d     = '0;
                    ovf_d      = 1'b0;
                    // Staying in StMeasure starts the next window with no dead cycle.
                    state_d    = continuous ? StMeasure : StIdle;
                end else begin
                    gate_d = gate_q + 1'b1;
                    edge_d = edge_nxt;
                    ovf_d  = ovf_nxt;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign freq_out = freq_q;
    assign overflow = overflow_q;
    assign valid    = valid_q;
    assign busy     = (state_q == StMeasure);

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
Measures the frequency of an asynchronous digital input by counting its rising edges over a fixed gate window of system-clock cycles. It is the receiving-side counterpart to the team's clock dividers: dividers generate known slow clocks, and this block reads a slow signal back as a number. With the default gate of one second at 50 MHz, the result is directly in Hz and feeds the seven-segment or LCD display path.

Parameters:
GATE_CYCLES, 50000000, gate window length in clock cycles (1 s at 50 MHz).
CNT_W, 27, width of the edge counter and of freq_out.

Ports:
clock  input  1  system clock (50 MHz)
reset  input  1  synchronous, active-high reset
sig_in  input  1  asynchronous signal to measure
start  input  1  one-cycle pulse; begins one measurement when idle
continuous  input  1  level; when 1, windows repeat back-to-back
freq_out  output  CNT_W  rising-edge count of last completed window (saturated)
valid  output  1  one-cycle pulse; freq_out/overflow updated this cycle
busy  output  1  1 while a window is in progress
overflow  output  1  last completed window saturated the counter

Behaviour:
- One clock domain (clock). Reset is synchronous and active-high and is sampled only on posedge clock.
- Reset values: freq_out=0, valid=0, busy=0, overflow=0, state=IDLE, all counters 0, synchronizer flops 0.
- Input conditioning: 3-flop chain s1->s2->s3 on sig_in. rise = s2 & ~s3. A sig_in edge reaches rise 2 cycles later. Glitches shorter than one clock may be missed; this is accepted.
- FSM states IDLE and MEASURE. The FSM state drives busy (busy=1 in MEASURE).
- IDLE -> MEASURE when start=1 or continuous=1. On entry, gate_cnt=0, edge_cnt=0, ovf=0.
- MEASURE, each cycle:
  - gate_cnt increments.
  - If rise=1, edge_cnt increments, saturating at 2^CNT_W-1. An increment attempted at the maximum sets ovf.
- Terminal cycle (gate_cnt==GATE_CYCLES-1):
  - A rise in this cycle is included.
  - freq_out <= final count (saturated); overflow <= final ovf; valid <= 1 for exactly the next cycle.
  - gate_cnt, edge_cnt and ovf are cleared.
  - If continuous=1, stay in MEASURE; the next window starts in the following cycle with no dead time, so no edge is lost between windows. Otherwise go to IDLE.
- start while in MEASURE is ignored; it neither restarts nor extends the window.
- continuous dropped mid-window: the current window completes and reports, then the FSM goes to IDLE.
- start and continuous both 1 in IDLE: same as continuous.
- freq_out and overflow hold their values between valid pulses. Reset is the only other path that changes them.
- Reset mid-window: window aborted, no valid pulse, all outputs return to 0.
- Width rules:
  - gate_cnt width is clog2(GATE_CYCLES).
  - Constraints: GATE_CYCLES >= 2, CNT_W >= 2.
  - The maximum measurable edge count is floor(GATE_CYCLES/2) for a synchronized signal; the default CNT_W covers it without saturation.

Decomposition:
- Shared package freq_meter_pkg:
  - state encoding constants IDLE/MEASURE;
  - default GATE_CYCLES and CNT_W;
  - a helper constant for gate counter width.
- One sub-module, sync_edge_det: the 3-flop synchronizer plus rising-edge detector. It is reusable for the debounced push-button path.
- The FSM and counters stay in freq_meter.

Test Plan:
(Bench overrides GATE_CYCLES=100, CNT_W=8 unless noted.)
1. sig_in period 10 clocks running before start; pulse start -> busy=1 for 100 cycles, single valid pulse, freq_out=10, overflow=0, then busy=0.
2. continuous=1, sig_in period 4 -> valid every 100 cycles with no gap, freq_out=25 each window. Drop continuous mid third window -> third valid with 25, then busy=0.
3. CNT_W=4, sig_in period 2 -> 50 edges exceed 15, so freq_out=15, overflow=1. Next window with sig_in=0 -> freq_out=0, overflow=0.
4. Assert reset at cycle 50 of a window -> next cycle all outputs 0, state IDLE, no valid pulse. A subsequent start measures normally.
5. Single sig_in rise timed so rise lands on the terminal cycle -> freq_out=1. Same rise one cycle later (continuous=1) -> counted in the next window, not lost.
6. start pulses repeated every 20 cycles during MEASURE -> exactly one valid per 100 cycles, window length unchanged.
